// File: rtl/palette_lut_bridge_pkg.sv
// Shared definitions for the indexed-colour bridge: colour helpers, default palette,
// control-register layout and the swap FSM state type.
package palette_pkg;

    localparam int unsigned CTRL_SWAP_REQ_BIT    = 0;
    localparam int unsigned CTRL_SWAP_PEND_BIT   = 0;
    localparam int unsigned CTRL_ACTIVE_BANK_BIT = 1;

    localparam int unsigned DEFAULT_COLOR_W = 16;
    localparam int unsigned DEFAULT_ENTRIES = 16;

    typedef enum logic [0:0] {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_e;

    function automatic logic [15:0] rgb565(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    localparam logic [15:0] COLOR_BLACK   = rgb565(8'h00, 8'h00, 8'h00);
    localparam logic [15:0] COLOR_WHITE   = rgb565(8'hFF, 8'hFF, 8'hFF);
    localparam logic [15:0] COLOR_RED     = rgb565(8'hFF, 8'h00, 8'h00);
    localparam logic [15:0] COLOR_GREEN   = rgb565(8'h00, 8'hFF, 8'h00);
    localparam logic [15:0] COLOR_BLUE    = rgb565(8'h00, 8'h00, 8'hFF);
    localparam logic [15:0] COLOR_CYAN    = rgb565(8'h00, 8'hFF, 8'hFF);
    localparam logic [15:0] COLOR_MAGENTA = rgb565(8'hFF, 8'h00, 8'hFF);
    localparam logic [15:0] COLOR_YELLOW  = rgb565(8'hFF, 8'hFF, 8'h00);

    // Power-up contents of one palette entry; the 8 base colours repeat over entries 0..15.
    function automatic logic [15:0] default_entry(input int unsigned idx,
                                                  input int unsigned color_w);
        logic [15:0] c;
        c = COLOR_BLACK;
        if (color_w == DEFAULT_COLOR_W && idx < DEFAULT_ENTRIES) begin
            case (idx[2:0])
                3'd0: c = COLOR_BLACK;
                3'd1: c = COLOR_WHITE;
                3'd2: c = COLOR_RED;
                3'd3: c = COLOR_GREEN;
                3'd4: c = COLOR_BLUE;
                3'd5: c = COLOR_CYAN;
                3'd6: c = COLOR_MAGENTA;
                3'd7: c = COLOR_YELLOW;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/palette_bank_ram.sv
// One palette bank: single write port, N_RD asynchronous read ports.
// Contents are set at power-up and are deliberately outside the reset domain.
module palette_bank_ram
    import palette_pkg::*;
#(
    parameter int unsigned IDX_W   = 8,
    parameter int unsigned COLOR_W = 16,
    parameter int unsigned N_RD    = 3
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_addr,
    input  logic [COLOR_W-1:0]        wr_data,
    input  logic [N_RD*IDX_W-1:0]     rd_addr,
    output logic [N_RD*COLOR_W-1:0]   rd_data
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    typedef logic [COLOR_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i] = COLOR_W'(default_entry(i, COLOR_W));
        end
        return m;
    endfunction

    mem_t mem_q = init_mem();

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < N_RD; i++) begin
            rd_data[i*COLOR_W +: COLOR_W] = mem_q[rd_addr[i*IDX_W +: IDX_W]];
        end
    end

endmodule

// File: rtl/palette_lut_bridge.sv
// Indexed-colour read bridge: forwards scan-out reads to framebuffer memory with row
// padding, translates returned pixel indices through a double-buffered palette.
module palette_lut_bridge
    import palette_pkg::*;
#(
    parameter int unsigned IDX_W        = 8,
    parameter int unsigned PIX_PER_WORD = 2,
    parameter int unsigned COLOR_W      = 16,
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned MAX_PENDING  = 4,
    parameter int unsigned ROW_SHIFT    = 8,
    parameter int unsigned PAD_WORDS    = 0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             avs_read,
    input  logic [ADDR_W-1:0]                avs_address,
    output logic                             avs_waitrequest,
    output logic [PIX_PER_WORD*COLOR_W-1:0]  avs_readdata,
    output logic                             avs_readdatavalid,
    output logic                             avm_read,
    output logic [ADDR_W-1:0]                avm_address,
    input  logic                             avm_waitrequest,
    input  logic [PIX_PER_WORD*IDX_W-1:0]    avm_readdata,
    input  logic                             avm_readdatavalid,
    input  logic [IDX_W:0]                   csr_address,
    input  logic                             csr_write,
    input  logic [COLOR_W-1:0]               csr_writedata,
    output logic [COLOR_W-1:0]               csr_readdata,
    input  logic                             frame_sync
);

    localparam int unsigned IN_W  = PIX_PER_WORD * IDX_W;
    localparam int unsigned OUT_W = PIX_PER_WORD * COLOR_W;
    localparam int unsigned N_RD  = PIX_PER_WORD + 1;
    localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);

    logic [CNT_W-1:0]    pending_q, pending_d;
    logic                s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]     s1_data_q, s1_data_d;
    logic                avs_readdatavalid_q, avs_readdatavalid_d;
    logic [OUT_W-1:0]    avs_readdata_q, avs_readdata_d;
    logic [COLOR_W-1:0]  csr_readdata_q, csr_readdata_d;
    logic                active_bank_q, active_bank_d;
    swap_state_e         swap_state_q, swap_state_d;

    logic                accept_c;
    logic [ADDR_W-1:0]   row_c;
    logic                ctrl_sel_c;
    logic                pal_we_c;
    logic                swap_req_c;
    logic [OUT_W-1:0]    lookup_c;
    logic [COLOR_W-1:0]  shadow_rd_c;
    logic [COLOR_W-1:0]  ctrl_rd_c;

    logic [N_RD*IDX_W-1:0]   bank_rd_addr;
    logic [N_RD*COLOR_W-1:0] bank0_rd_data;
    logic [N_RD*COLOR_W-1:0] bank1_rd_data;

    // Combinational request forwarding and row-padding address translation.
    always_comb begin
        avm_read        = avs_read && (pending_q < PEND_MAX);
        avs_waitrequest = avm_waitrequest || (pending_q == PEND_MAX);
        accept_c        = avs_read && !avs_waitrequest;
        row_c           = avs_address >> ROW_SHIFT;
        avm_address     = avs_address + ADDR_W'(row_c * ADDR_W'(PAD_WORDS));
    end

    always_comb begin
        pending_d = pending_q;
        case ({accept_c, avs_readdatavalid_q})
            2'b10:   pending_d = pending_q + CNT_W'(1);
            2'b01:   pending_d = pending_q - CNT_W'(1);
            default: pending_d = pending_q;
        endcase
    end

    // Lookup ports carry the S1 index fields; the top port serves CSR reads.
    assign bank_rd_addr = {csr_address[IDX_W-1:0], s1_data_q};

    palette_bank_ram #(
        .IDX_W   (IDX_W),
        .COLOR_W (COLOR_W),
        .N_RD    (N_RD)
    ) u_bank0 (
        .clk     (clk),
        .wr_en   (pal_we_c && active_bank_q),
        .wr_addr (csr_address[IDX_W-1:0]),
        .wr_data (csr_writedata),
        .rd_addr (bank_rd_addr),
        .rd_data (bank0_rd_data)
    );

    palette_bank_ram #(
        .IDX_W   (IDX_W),
        .COLOR_W (COLOR_W),
        .N_RD    (N_RD)
    ) u_bank1 (
        .clk     (clk),
        .wr_en   (pal_we_c && !active_bank_q),
        .wr_addr (csr_address[IDX_W-1:0]),
        .wr_data (csr_writedata),
        .rd_addr (bank_rd_addr),
        .rd_data (bank1_rd_data)
    );

    // Two-stage pipeline: S1 captures indices, S2 registers the translated colours.
    always_comb begin
        lookup_c            = active_bank_q ? bank1_rd_data[OUT_W-1:0]
                                            : bank0_rd_data[OUT_W-1:0];
        s1_valid_d          = avm_readdatavalid;
        s1_data_d           = avm_readdatavalid ? avm_readdata : s1_data_q;
        avs_readdatavalid_d = s1_valid_q;
        avs_readdata_d      = s1_valid_q ? lookup_c : avs_readdata_q;
    end

    always_comb begin
        ctrl_sel_c  = csr_address[IDX_W];
        pal_we_c    = csr_write && !ctrl_sel_c;
        swap_req_c  = csr_write && ctrl_sel_c && csr_writedata[CTRL_SWAP_REQ_BIT];
        shadow_rd_c = active_bank_q ? bank0_rd_data[OUT_W +: COLOR_W]
                                    : bank1_rd_data[OUT_W +: COLOR_W];
        ctrl_rd_c                       = '0;
        ctrl_rd_c[CTRL_SWAP_PEND_BIT]   = (swap_state_q == SWAP_PENDING);
        ctrl_rd_c[CTRL_ACTIVE_BANK_BIT] = active_bank_q;
        csr_readdata_d = ctrl_sel_c ? ctrl_rd_c : shadow_rd_c;
    end

    // Swap FSM: a request taken together with frame_sync swaps immediately.
    always_comb begin
        swap_state_d  = swap_state_q;
        active_bank_d = active_bank_q;
        case (swap_state_q)
            SWAP_IDLE: begin
                if (swap_req_c) begin
                    if (frame_sync) begin
                        active_bank_d = !active_bank_q;
                    end else begin
                        swap_state_d = SWAP_PENDING;
                    end
                end
            end
            SWAP_PENDING: begin
                if (frame_sync) begin
                    active_bank_d = !active_bank_q;
                    swap_state_d  = SWAP_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q           <= '0;
            s1_valid_q          <= 1'b0;
            s1_data_q           <= '0;
            avs_readdatavalid_q <= 1'b0;
            avs_readdata_q      <= '0;
            csr_readdata_q      <= '0;
            active_bank_q       <= 1'b0;
            swap_state_q        <= SWAP_IDLE;
        end else begin
            pending_q           <= pending_d;
            s1_valid_q          <= s1_valid_d;
            s1_data_q           <= s1_data_d;
            avs_readdatavalid_q <= avs_readdatavalid_d;
            avs_readdata_q      <= avs_readdata_d;
            csr_readdata_q      <= csr_readdata_d;
            active_bank_q       <= active_bank_d;
            swap_state_q        <= swap_state_d;
        end
    end

    assign avs_readdatavalid = avs_readdatavalid_q;
    assign avs_readdata      = avs_readdata_q;
    assign csr_readdata      = csr_readdata_q;

endmodule
